// File: rtl/pipe_skid_stage.sv
// Multi-lane pipeline stage with a two-entry skid buffer, a registered in_ready,
// flush, per-lane valid masks and a saturating count of starved cycles.
module pipe_skid_stage #(
  parameter int unsigned          DATA_W   = 32,
  parameter int unsigned          LANES    = 2,
  parameter logic [DATA_W-1:0]    NOP_WORD = '0,
  parameter int unsigned          CNT_W    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_vld,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_lane_vld,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [1:0]              occupancy,
  output logic [CNT_W-1:0]        bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    in_ready_q;
  logic [LANES-1:0]        main_mask_q, skid_mask_q;
  logic [LANES*DATA_W-1:0] main_data_q, skid_data_q;
  logic [CNT_W-1:0]        bubble_q, bubble_d;

  logic in_fire, out_fire, keep;

  assign in_fire  = in_valid & in_ready_q;
  assign out_fire = out_valid & out_ready;
  // Entries with no valid lane are consumed but never occupy storage.
  assign keep     = in_fire & (|in_lane_vld);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state_q     <= EMPTY;
      in_ready_q  <= 1'b1;
      main_mask_q <= '0;
      skid_mask_q <= '0;
      main_data_q <= {LANES{NOP_WORD}};
      skid_data_q <= {LANES{NOP_WORD}};
    end else begin
      case (state_q)
        EMPTY: begin
          if (keep) begin
            main_mask_q <= in_lane_vld;
            main_data_q <= in_data;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (out_fire && keep) begin
            main_mask_q <= in_lane_vld;
            main_data_q <= in_data;
          end else if (out_fire) begin
            state_q <= EMPTY;
          end else if (keep) begin
            skid_mask_q <= in_lane_vld;
            skid_data_q <= in_data;
            state_q     <= FULL;
            in_ready_q  <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_mask_q <= skid_mask_q;
            main_data_q <= skid_data_q;
            state_q     <= ONE;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q    <= EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Starvation counter survives flush; only rst clears it.
  always_comb begin
    bubble_d = bubble_q;
    if (out_ready && !out_valid && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_q <= '0;
    end else begin
      bubble_q <= bubble_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = (state_q != EMPTY);
  assign out_lane_vld = out_valid ? main_mask_q : '0;
  assign occupancy    = state_q;
  assign bubble_cnt   = bubble_q;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign out_data[gi*DATA_W +: DATA_W] = out_lane_vld[gi] ?
          main_data_q[gi*DATA_W +: DATA_W] : NOP_WORD;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomized checks of pipe_skid_stage against a queue-based model.
module tb_pipe_skid_stage;
  localparam int DATA_W = 32;
  localparam int LANES  = 2;
  localparam int CNT_W  = 4;
  localparam logic [DATA_W-1:0] NOP = 32'h0;
  localparam int BUB_MAX = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [LANES-1:0]        in_lane_vld, out_lane_vld;
  logic [LANES*DATA_W-1:0] in_data, out_data;
  logic [1:0]              occupancy;
  logic [CNT_W-1:0]        bubble_cnt;

  pipe_skid_stage #(.DATA_W(DATA_W), .LANES(LANES), .NOP_WORD(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_lane_vld(in_lane_vld), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_vld(out_lane_vld),
    .out_data(out_data), .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES-1:0]        m;
    logic [LANES*DATA_W-1:0] d;
  } ent_t;

  ent_t q[$];
  int   bub;
  bit   known;
  int   total, bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [LANES*DATA_W-1:0] exp_data();
    logic [LANES*DATA_W-1:0] r;
    for (int i = 0; i < LANES; i++) begin
      if (q.size() > 0 && q[0].m[i]) r[i*DATA_W +: DATA_W] = q[0].d[i*DATA_W +: DATA_W];
      else                           r[i*DATA_W +: DATA_W] = NOP;
    end
    return r;
  endfunction

  // One clock cycle: drive, check the held state, advance the model, take the edge.
  task automatic step(input bit r, input bit f, input bit v, input logic [1:0] m,
                      input logic [63:0] d, input bit ordy);
    bit acc, pop;
    @(negedge clk);
    rst = r; flush = f; in_valid = v; in_lane_vld = m; in_data = d; out_ready = ordy;
    #1;
    if (known) begin
      check("out_valid", out_valid, q.size() > 0);
      check("in_ready", in_ready, q.size() < 2);
      check("occupancy", occupancy, q.size());
      check("lane_vld", out_lane_vld, q.size() > 0 ? q[0].m : 2'b00);
      check("out_data", out_data, exp_data());
      check("bubble", bubble_cnt, bub);
      $display("t=%0t rst=%0b fl=%0b iv=%0b m=%b d=%h ordy=%0b | ov=%0b ir=%0b occ=%0d od=%h bub=%0d",
               $time, r, f, v, m, d, ordy, out_valid, in_ready, occupancy, out_data, bubble_cnt);
    end
    acc = v && (q.size() < 2);
    pop = ordy && (q.size() > 0);
    if (r) bub = 0;
    else if (ordy && q.size() == 0 && bub < BUB_MAX) bub++;
    if (r || f) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (acc && m != 2'b00) q.push_back('{m: m, d: d});
    end
    if (r) known = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    total = 0; bad = 0; bub = 0; known = 1'b0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_lane_vld = '0; in_data = '0; out_ready = 1'b0;

    // reset then idle
    step(1, 0, 0, 2'b00, 64'h0, 0);
    step(1, 0, 0, 2'b00, 64'h0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 2'b00, 64'h0, 1);
    #1;
    check("idle_bubble5", bubble_cnt, 5);
    check("idle_data_nop", out_data, 64'h0);

    // streaming A..E
    for (int i = 1; i <= 5; i++)
      step(0, 0, 1, 2'b11, {32'(i * 16 + 2), 32'(i * 16 + 1)}, 1);
    step(0, 0, 0, 2'b00, 64'h0, 1);
    step(0, 0, 0, 2'b00, 64'h0, 1);

    // backpressure: A, B stored, C held upstream, then drain
    step(0, 0, 1, 2'b11, 64'h0000_00A2_0000_00A1, 0);
    step(0, 0, 1, 2'b11, 64'h0000_00B2_0000_00B1, 0);
    step(0, 0, 1, 2'b11, 64'h0000_00C2_0000_00C1, 0);
    step(0, 0, 1, 2'b11, 64'h0000_00C2_0000_00C1, 0);
    step(0, 0, 1, 2'b11, 64'h0000_00C2_0000_00C1, 1);
    step(0, 0, 1, 2'b11, 64'h0000_00C2_0000_00C1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b00, 64'h0, 1);

    // lane masking and dropped all-zero entry
    step(0, 0, 1, 2'b01, 64'hAAAA_0000_0000_BBBB, 0);
    step(0, 0, 1, 2'b00, 64'h1234_5678_9ABC_DEF0, 0);
    step(0, 0, 0, 2'b00, 64'h0, 0);
    step(0, 0, 0, 2'b00, 64'h0, 1);

    // flush from FULL while offering D
    step(0, 0, 1, 2'b11, 64'h0000_0001_0000_0002, 0);
    step(0, 0, 1, 2'b10, 64'h0000_0003_0000_0004, 0);
    step(0, 1, 1, 2'b11, 64'h0000_00D2_0000_00D1, 0);
    step(0, 0, 0, 2'b00, 64'h0, 0);
    step(0, 0, 0, 2'b00, 64'h0, 1);

    // saturation
    step(1, 0, 0, 2'b00, 64'h0, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 2'b00, 64'h0, 1);
    #1;
    check("bubble_sat", bubble_cnt, 15);
    step(0, 0, 0, 2'b00, 64'h0, 1);
    #1;
    check("bubble_hold", bubble_cnt, 15);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0,
           $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)),
           {$urandom, $urandom}, $urandom_range(0, 2) != 0);
    end
    step(0, 0, 0, 2'b00, 64'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Parametrised, multi-lane pipeline stage register.
- Next generation of the fixed decode-to-execute latch: replaces the global stall vector with per-stage ready/valid handshake, adds a 2-entry skid buffer, flush, per-lane valid masks and a starvation counter.
- Sits between any two pipeline stages (ID->EX, EX->MEM, ...). Delivers full throughput while keeping `in_ready` a pure register output.

Parameters:
- DATA_W, 32, payload bits per lane.
- LANES, 2, number of parallel issue lanes.
- NOP_WORD, 0, per-lane payload value driven on an empty or invalid lane.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  discard all held entries.
- in_valid  input  1  upstream offers an entry.
- in_ready  output  1  stage can accept an entry; registered.
- in_lane_vld  input  LANES  per-lane valid mask of the offered entry.
- in_data  input  LANES*DATA_W  lane i in bits [i*DATA_W +: DATA_W].
- out_valid  output  1  `main` entry valid.
- out_ready  input  1  downstream accepts.
- out_lane_vld  output  LANES  lane mask of the `main` entry.
- out_data  output  LANES*DATA_W  payload of the `main` entry.
- occupancy  output  2  number of held entries, 0..2.
- bubble_cnt  output  CNT_W  saturating count of starved cycles.

Behaviour:
- Storage is two entries: `main` (drives the outputs) and `skid`. Each entry holds a lane mask and a payload.
- States: EMPTY (occ 0), ONE (`main` only), FULL (`main` and `skid`).
- Handshake signals:
  - `in_fire` = in_valid & in_ready.
  - `out_fire` = out_valid & out_ready.
  - `keep` = in_fire & (|in_lane_vld).
  - An `in_fire` with an all-zero mask is consumed and dropped; it is never stored.
- Transitions, evaluated on each posedge when not rst and not flush:
  - EMPTY: `keep` -> `main` <= in, go to ONE. Otherwise stay.
  - ONE, `out_fire` and `keep`: `main` <= in, stay ONE.
  - ONE, `out_fire` only: go to EMPTY.
  - ONE, `keep` only: `skid` <= in, go to FULL.
  - ONE, neither: hold.
  - FULL (in_ready=0): `out_fire` -> `main` <= `skid`, go to ONE. Otherwise hold.
- in_ready = (state != FULL), registered. It drops in the cycle after an entry fills `skid` and rises in the cycle after `skid` drains.
- Latency and throughput:
  - Latency is 1 cycle: an entry accepted at edge N appears on `out_*` after edge N.
  - Throughput is 1 entry per cycle whenever `out_ready` is held high.
- Outputs:
  - out_valid = (state != EMPTY).
  - out_lane_vld = `main` mask when valid, else 0.
  - out_data lane i = `main` payload lane i when out_valid and out_lane_vld[i]; otherwise NOP_WORD.
  - Every invalid lane and the entire empty stage read as NOP_WORD.
- Ordering: strict FIFO. `skid` is always younger than `main`.
- Stability: while out_valid=1 and out_ready=0, out_* are held bit-stable.
- flush:
  - Priority over all handshake activity. Next state is EMPTY, both entries' masks are cleared, and payloads are set to NOP_WORD.
  - An `in_fire` in the flush cycle is discarded. in_ready is 1 after the flush edge.
  - bubble_cnt is not affected.
- rst: same effect as flush, and additionally bubble_cnt <= 0.
- Reset values:
  - in_ready=1, out_valid=0, out_lane_vld=0.
  - out_data = NOP_WORD in every lane.
  - occupancy=0, bubble_cnt=0.
- bubble_cnt:
  - Increments by 1 on every edge where out_ready=1 and out_valid=0, and rst=0.
  - Saturates at 2^CNT_W-1 (no wrap).
  - Counts the cycle in which flush is asserted if the condition holds.
- rst or flush arriving in FULL with in_valid=1: both entries are lost, as specified above. Upstream must re-present after in_ready=1.
- occupancy mirrors state: 0, 1 or 2.

Test Plan:
- Reset/idle: assert rst 2 cycles, then in_valid=0, out_ready=1 for 5 cycles -> all outputs at reset values; bubble_cnt=5; out_data=0 in both lanes.
- Streaming: in_valid=1, out_ready=1, send A=0x11/0x12 through E=0x51/0x52 with mask 2'b11 on consecutive cycles -> out_valid on 5 consecutive cycles, each entry 1 cycle after acceptance, in order A..E; in_ready stays 1; occupancy stays 1.
- Backpressure: send A, B, C back-to-back with out_ready=0 -> A in `main`, B in `skid`; in_ready=0 from the cycle after B is accepted; occupancy=2; C held upstream. Raise out_ready -> A, B, C emerge in order with no loss or duplication; out_data stable while stalled.
- Lane masking: send entry mask 2'b01, data 0xAAAA_0000/0x0000_BBBB -> out_lane_vld=01, lane0=0x0000_BBBB, lane1=NOP_WORD. Then send mask 2'b00 -> entry dropped, out_valid unchanged, occupancy unchanged.
- Flush: fill to FULL, then assert flush with in_valid=1, data D -> next cycle out_valid=0, occupancy=0, in_ready=1, D absent; bubble_cnt not reset.
- Saturation: CNT_W=4, out_ready=1, no input for 20 cycles -> bubble_cnt reaches 15 and holds 15.
